// File: rtl/npc_lsu.sv
// ---------------------------------------------------------------------------
// npc_lsu - load/store unit for the npc core.
//
// Accepts one RV32I load/store at a time from the execute stage, issues it as
// a single handshaked bus transaction with byte strobes, and returns the
// extended load data plus an error code. A transaction is finished by a bus
// response, a bus error, or a wait timeout. Misaligned or illegal requests
// complete without touching the bus.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_*               core request (valid/ready, store flag, funct3,
//                       byte address, store data)
//   rsp_*               core response (valid/ready, load data, error code)
//   mem_req_*, mem_wen, mem_addr, mem_wdata, mem_wmask
//                       bus request, held stable until mem_req_ready
//   mem_rsp_*           bus response (single-cycle valid, data, error)
// ---------------------------------------------------------------------------
module npc_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  input  logic                mem_rsp_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_BUS     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic               wen_q;
  logic [2:0]         funct3_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rdata_q;
  logic [1:0]         err_q;

  // Request screening. Loads reject 011/11x, stores reject 011/1xx.
  logic req_illegal, req_misaligned, req_bad;
  assign req_illegal    = req_wen ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                                  : ((req_funct3[1:0] == 2'b11) || (req_funct3[2] && req_funct3[1]));
  assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_bad        = req_illegal || req_misaligned;

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  // Lane offset of the registered request inside one bus word.
  logic [OFF_W-1:0] off;
  assign off = addr_q[OFF_W-1:0];

  // Load extraction: bring the addressed byte to bit 0, then extend.
  logic [DATA_W-1:0] rdata_shift;
  logic [31:0]       load_data;
  always_comb begin
    rdata_shift = mem_rsp_rdata >> {off, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_data = {24'h0, rdata_shift[7:0]};
      3'b101:  load_data = {16'h0, rdata_shift[15:0]};
      default: load_data = rdata_shift[31:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. A timeout abandons a request still waiting in REQ; a
  // response arriving in the same cycle as the timeout in WAIT wins.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid)          state_d = req_bad ? RESP : REQ;
      REQ:  if (timeout_hit)        state_d = RESP;
            else if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid)      state_d = RESP;
            else if (timeout_hit)   state_d = RESP;
      RESP: if (rsp_ready)          state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Request capture, timeout counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      wen_q    <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_OK;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          wen_q    <= req_wen;
          funct3_q <= req_funct3;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          cnt_q    <= '0;
          rdata_q  <= '0;
          err_q    <= req_bad ? ERR_ALIGN : ERR_OK;
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (timeout_hit) err_q <= ERR_TIMEOUT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_rsp_valid) begin
            err_q <= mem_rsp_err ? ERR_BUS : ERR_OK;
            if (!mem_rsp_err && !wen_q) rdata_q <= load_data;
          end else if (timeout_hit) begin
            err_q <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs, all derived from registered state.
  logic [STRB_W-1:0] size_mask;
  always_comb begin
    size_mask = '0;
    case (funct3_q[1:0])
      2'b00:   size_mask[0]   = 1'b1;
      2'b01:   size_mask[1:0] = 2'b11;
      default: size_mask[3:0] = 4'hF;
    endcase

    req_ready     = (state_q == IDLE);
    mem_req_valid = (state_q == REQ);
    rsp_valid     = (state_q == RESP);
    rsp_rdata     = rdata_q;
    rsp_err       = err_q;
    mem_wen       = wen_q;
    mem_addr      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    mem_wmask     = wen_q ? (size_mask << off) : '0;

    // Replicate the store data so whichever lane the strobes select holds
    // the right byte; alignment guarantees lane off carries wdata[7:0].
    mem_wdata = '0;
    for (int i = 0; i < STRB_W; i++) begin
      case (funct3_q[1:0])
        2'b00:   mem_wdata[i*8 +: 8] = wdata_q[7:0];
        2'b01:   mem_wdata[i*8 +: 8] = wdata_q[(i % 2)*8 +: 8];
        default: mem_wdata[i*8 +: 8] = wdata_q[(i % 4)*8 +: 8];
      endcase
    end
  end

endmodule

// File: tb/tb_npc_lsu.sv
// ---------------------------------------------------------------------------
// tb_npc_lsu - directed bench for npc_lsu.
//
// Two instances share one set of inputs: u_dut32 (DATA_W=32, TIMEOUT=255)
// and u_dut64 (DATA_W=64, TIMEOUT=4). Each scenario observes whichever
// instance it targets. Inputs change 1 ns after the rising edge and outputs
// are sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_npc_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_wen, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req_ready, mem_rsp_valid, mem_rsp_err;
  logic [63:0] mem_rsp_rdata;

  logic        a_req_ready, a_rsp_valid, a_mem_req_valid, a_mem_wen;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [1:0]  a_rsp_err;
  logic [3:0]  a_mem_wmask;

  logic        b_req_ready, b_rsp_valid, b_mem_req_valid, b_mem_wen;
  logic [31:0] b_rsp_rdata, b_mem_addr;
  logic [63:0] b_mem_wdata;
  logic [1:0]  b_rsp_err;
  logic [7:0]  b_mem_wmask;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  npc_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wmask(a_mem_wmask), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata[31:0]), .mem_rsp_err(mem_rsp_err)
  );

  npc_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(4)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wmask(b_mem_wmask), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Present a request in IDLE; returns in cycle 1 with req_valid dropped.
  task automatic issue(input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0;
  endtask

  task automatic bus_accept();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
  endtask

  task automatic bus_respond(input logic [63:0] data, input logic err);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = data; mem_rsp_err = err;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_wen = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0;
    mem_rsp_rdata = 0;
    reset = 1'b1;
    #1;
    step();
    step();
    // Reset values while reset is still asserted.
    check("rst_mem_req_valid", a_mem_req_valid, 0);
    check("rst_rsp_valid",     a_rsp_valid, 0);
    check("rst_rsp_rdata",     a_rsp_rdata, 0);
    check("rst_rsp_err",       a_rsp_err, 0);
    check("rst_wmask",         a_mem_wmask, 0);
    reset = 1'b0;
    step();
    check("rst_req_ready",     a_req_ready, 1);

    // lw 0x80000004 on the 64-bit bus: upper word selected.
    issue(1'b0, 3'b010, 32'h8000_0004, 32'h0);
    check("lw64_c1_mem_req_valid", b_mem_req_valid, 1);
    check("lw64_c1_mem_addr",      b_mem_addr, 32'h8000_0000);
    check("lw64_c1_wmask",         b_mem_wmask, 0);
    check("lw64_c1_req_ready",     b_req_ready, 0);
    bus_accept();
    check("lw64_c2_mem_req_valid", b_mem_req_valid, 0);
    check("lw64_c2_rsp_valid",     b_rsp_valid, 0);
    bus_respond(64'h1122_3344_AABB_CCDD, 1'b0);
    check("lw64_c3_rsp_valid",     b_rsp_valid, 1);
    check("lw64_c3_rdata",         b_rsp_rdata, 32'h1122_3344);
    check("lw64_c3_err",           b_rsp_err, 0);
    finish_rsp();
    check("lw64_c4_req_ready",     b_req_ready, 1);
    check("lw64_c4_rsp_valid",     b_rsp_valid, 0);

    // lb / lbu at byte lane 3 of a 32-bit word.
    issue(1'b0, 3'b000, 32'h8000_0003, 32'h0);
    bus_accept();
    bus_respond(64'h0000_0000_80FF_0000, 1'b0);
    check("lb_rdata", a_rsp_rdata, 32'hFFFF_FF80);
    finish_rsp();
    issue(1'b0, 3'b100, 32'h8000_0003, 32'h0);
    bus_accept();
    bus_respond(64'h0000_0000_80FF_0000, 1'b0);
    check("lbu_rdata", a_rsp_rdata, 32'h0000_0080);
    finish_rsp();

    // sh at 0x80000006: upper half lanes.
    issue(1'b1, 3'b001, 32'h8000_0006, 32'h0000_BEEF);
    check("sh_mem_addr",   a_mem_addr, 32'h8000_0004);
    check("sh_wmask",      a_mem_wmask, 4'b1100);
    check("sh_wdata_hi",   a_mem_wdata[31:16], 16'hBEEF);
    check("sh_mem_wen",    a_mem_wen, 1);
    check("sh64_wmask",    b_mem_wmask, 8'hC0);
    check("sh64_wdata_hi", b_mem_wdata[63:48], 16'hBEEF);
    bus_accept();
    bus_respond(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("sh_rsp_valid",  a_rsp_valid, 1);
    check("sh_rdata",      a_rsp_rdata, 0);
    check("sh_err",        a_rsp_err, 0);
    finish_rsp();

    // sb at lane 1.
    issue(1'b1, 3'b000, 32'h8000_0001, 32'h1234_56A5);
    check("sb_wmask",  a_mem_wmask, 4'b0010);
    check("sb_wdata",  a_mem_wdata[15:8], 8'hA5);
    bus_accept();
    bus_respond(64'h0, 1'b0);
    finish_rsp();

    // Misaligned lw: no bus request, response in cycle 1.
    issue(1'b0, 3'b010, 32'h8000_0002, 32'h0);
    check("mis_mem_req_valid", a_mem_req_valid, 0);
    check("mis_rsp_valid",     a_rsp_valid, 1);
    check("mis_err",           a_rsp_err, 2'b01);
    check("mis_rdata",         a_rsp_rdata, 0);
    finish_rsp();
    // Illegal store funct3 100.
    issue(1'b1, 3'b100, 32'h8000_0000, 32'h0);
    check("ill_mem_req_valid", a_mem_req_valid, 0);
    check("ill_err",           a_rsp_err, 2'b01);
    finish_rsp();

    // Bus stall for 3 cycles, then a bus error.
    do_reset();
    issue(1'b0, 3'b010, 32'h8000_0008, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("stall_mem_req_valid", a_mem_req_valid, 1);
      check("stall_mem_addr",      a_mem_addr, 32'h8000_0008);
      check("stall_mem_wen",       a_mem_wen, 0);
      if (i == 3) mem_req_ready = 1'b1;
      step();
    end
    mem_req_ready = 1'b0;
    bus_respond(64'h0000_0000_DEAD_BEEF, 1'b1);
    check("buserr_rsp_valid", a_rsp_valid, 1);
    check("buserr_err",       a_rsp_err, 2'b10);
    check("buserr_rdata",     a_rsp_rdata, 0);
    finish_rsp();

    // Timeout on the TIMEOUT=4 instance: counter is 4 in cycle 5,
    // response in cycle 6.
    do_reset();
    issue(1'b0, 3'b010, 32'h8000_0000, 32'h0);
    step(); step(); step(); step();
    check("to_c5_rsp_valid",     b_rsp_valid, 0);
    check("to_c5_mem_req_valid", b_mem_req_valid, 1);
    step();
    check("to_c6_rsp_valid",     b_rsp_valid, 1);
    check("to_c6_err",           b_rsp_err, 2'b11);
    check("to_c6_mem_req_valid", b_mem_req_valid, 0);
    check("to_c6_rdata",         b_rsp_rdata, 0);
    bus_respond(64'h5555_5555_5555_5555, 1'b0);
    check("to_late_err",   b_rsp_err, 2'b11);
    check("to_late_rdata", b_rsp_rdata, 0);
    finish_rsp();
    bus_respond(64'h5555_5555_5555_5555, 1'b0);
    check("to_idle_rsp_valid", b_rsp_valid, 0);
    check("to_idle_req_ready", b_req_ready, 1);

    // Reset in WAIT with a response pending on the bus.
    do_reset();
    issue(1'b0, 3'b010, 32'h8000_0000, 32'h0);
    bus_accept();
    reset = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1;
    step();
    reset = 1'b0; mem_rsp_valid = 1'b0;
    check("rstw_req_ready",     a_req_ready, 1);
    check("rstw_rsp_valid",     a_rsp_valid, 0);
    check("rstw_mem_req_valid", a_mem_req_valid, 0);
    step();
    check("rstw_after_rsp_valid", a_rsp_valid, 0);

    // lh with rsp_ready held low for 5 cycles.
    issue(1'b0, 3'b001, 32'h8000_0002, 32'h0);
    bus_accept();
    bus_respond(64'h0000_0000_8001_1234, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", a_rsp_valid, 1);
      check("hold_rdata",     a_rsp_rdata, 32'hFFFF_8001);
      check("hold_err",       a_rsp_err, 0);
      step();
    end
    finish_rsp();
    check("hold_done_req_ready", a_req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/npc_lsu.md
# npc_lsu

Load/store unit for the next-generation npc core. It replaces the combinational DPI memory read with a multi-cycle, handshaked memory port. It supports all RV32I load/store widths, byte-lane masking over a parametrised data bus, misalignment detection, bus errors and a wait timeout. It sits between the core's execute stage (request/response side) and the memory/bus adapter (mem side).

## Interface
Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: memory bus data width, 32 or 64. OFF_W = log2(DATA_W/8).
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit idle and able to accept.
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and for errors.
- rsp_err  out  2  00 ok, 01 misaligned/illegal funct3, 10 bus error, 11 timeout.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_wen  out  1  bus write.
- mem_addr  out  ADDR_W  req_addr with low OFF_W bits cleared.
- mem_wdata  out  DATA_W  lane-positioned store data.
- mem_wmask  out  DATA_W/8  byte strobes; all zero for loads.
- mem_rsp_valid  in  1  bus response valid (single cycle).
- mem_rsp_rdata  in  DATA_W  bus read data.
- mem_rsp_err  in  1  bus error flag, qualified by mem_rsp_valid.

## Operation
- States: IDLE, REQ, WAIT, RESP. Request fields are registered on accept; mem_* outputs are driven from these registers.
- IDLE:
  - req_ready = 1.
  - On req_valid, the request is accepted.
  - Misaligned (h with addr[0] != 0; w with addr[1:0] != 0) or illegal funct3 (loads 011/11x; stores 1xx/011) → RESP with err 01. No bus access is made.
  - Otherwise → REQ.
- REQ:
  - mem_req_valid = 1. mem_req_valid and all mem_* fields stay stable until mem_req_ready.
  - On mem_req_ready → WAIT.
- WAIT:
  - On mem_rsp_valid → RESP, err = mem_rsp_err ? 10 : 00.
  - Load data is captured only when err = 00.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready → IDLE.
- Lane mapping, with off = addr[OFF_W-1:0]:
  - Size mask: b = 0x1, h = 0x3, w = 0xF.
  - mem_wmask = size mask << off.
  - mem_wdata = store data replicated across the bus, so the byte at lane off equals wdata[7:0].
- Load extract: shift mem_rsp_rdata right by off*8, take the low 8/16/32 bits, then sign-extend (lb, lh) or zero-extend (lbu, lhu).
- Timeout counter:
  - Cleared on accept; increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT (and TIMEOUT != 0) → RESP, err 11. The request is abandoned: mem_req_valid drops.
- mem_rsp_valid outside WAIT is ignored, including late responses after a timeout.

## Timing
- Reset values (at and after the reset cycle): state IDLE, counter 0, mem_req_valid 0, rsp_valid 0, rsp_rdata 0, rsp_err 00, mem_wmask 0. req_ready = 1 from the first cycle after reset.
- Best-case latency, with cycle 0 = accept edge:
  - Cycle 1: REQ, mem_req_valid = 1, mem_req_ready = 1.
  - Cycle 2: WAIT, mem_rsp_valid = 1.
  - Cycle 3: rsp_valid = 1.
  - Next accept possible at cycle 4 if rsp_ready = 1 at cycle 3.
- Misaligned/illegal request: rsp_valid in cycle 1.
- Throughput: one outstanding transaction; req_ready = 0 outside IDLE.
- Timeout at cycle count TIMEOUT → rsp_valid on the following cycle.
- mem_req_ready and mem_rsp_valid both high in REQ: the response is not sampled. The bus must not respond before WAIT.
- Reset mid-transaction: returns to IDLE next cycle, drops mem_req_valid and rsp_valid, and discards any pending bus response.

## Test plan
- lw at 0x80000004, DATA_W=64, bus returns 0x11223344_AABBCCDD → mem_addr 0x80000000, rsp_rdata 0x11223344, err 00, rsp_valid 3 cycles after accept.
- lb then lbu at 0x80000003, DATA_W=32, bus data 0x80FF0000 → rsp_rdata 0xFFFFFF80 then 0x00000080.
- sh at 0x80000006, wdata 0x0000BEEF, DATA_W=32 → mem_addr 0x80000004, mem_wmask 0b1100, mem_wdata[31:16] = 0xBEEF, rsp_rdata 0.
- lw at 0x80000002 → no mem_req_valid, rsp_valid at cycle 1, err 01. Store funct3 100 → err 01.
- mem_req_ready held low for 3 cycles, then mem_rsp_err = 1 → mem_* fields stable throughout, err 10, rsp_rdata 0. Same bench with TIMEOUT=4 and no response → err 11, and a late mem_rsp_valid is ignored.
- Reset asserted while in WAIT → next cycle req_ready = 1 and rsp_valid = 0. rsp_ready held low 5 cycles in RESP → rsp_rdata and rsp_err held unchanged.
